fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Dual-width instruction queue between fetch stage 2 and the decode stage.
- Absorbs up to two fetched instructions per cycle and presents the two oldest entries to decode.
- Pops 0, 1 or 2 entries per cycle. One pop covers the case where decode flags branch_misalign: the jump in the younger slot is held back and re-presented as the older slot next cycle, together with its delay slot.
- Decouples I-cache stalls from decode stalls and is cleared on pipeline redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  redirect/exception; discard all contents and this cycle's push
- in_data  in  2 x fetch_data_t  from F2; [1] is older, [0] is younger; per-slot valid
- in_ready  out  1  buffer can accept a full two-entry push this cycle
- out_data  out  2 x fetch_data_t  to decode dataF2; [1] is the head (oldest), [0] is head+1
- stall  in  1  decode/issue cannot consume this cycle
- branch_misalign  in  1  from decode; out_data[0] is a jump whose delay slot is not yet present
- count  out  clog2(DEPTH)+1  current occupancy (debug/perf)

Behaviour:
- Storage: DEPTH-entry circular array, head pointer, tail pointer (clog2(DEPTH) bits, wrap modulo DEPTH), and a count register.
- Reset (resetn=0 at posedge):
  - head=tail=count=0.
  - out_data[1].valid=out_data[0].valid=0 in the following cycle.
  - in_ready=1.
  - Storage contents are don't-care.
- in_ready = (DEPTH - count >= 2), combinational from the registered count. It does not depend on same-cycle pops.
- Push is accepted only when in_ready=1 and flush=0. F2 holds its data while in_ready=0.
- Push compaction:
  - in_data[1].valid and in_data[0].valid: write in_data[1] to tail, in_data[0] to tail+1; push_n=2.
  - Only in_data[1] valid: write it to tail; push_n=1.
  - Only in_data[0] valid: write it to tail; push_n=1.
  - Neither valid: push_n=0.
  - Age order is always preserved.
- Output (combinational read of registered storage):
  - out_data[1] = mem[head], valid = count>=1.
  - out_data[0] = mem[head+1], valid = count>=2.
  - Invalid slots present valid=0 and don't-care payload.
  - Latency: an entry pushed at edge N is visible on out_data after edge N (one-cycle fall-through). There is no bypass from in_data to out_data.
- Pop count:
  - stall=1: pop_n=0.
  - stall=0 and out[0].valid and !branch_misalign: pop_n=2.
  - stall=0 and out[1].valid and (branch_misalign or !out[0].valid): pop_n=1.
  - Otherwise: pop_n=0.
  - branch_misalign is ignored when out[0].valid=0.
- Update on each clock edge: head+=pop_n, tail+=push_n, count = count + push_n - pop_n.
  - A simultaneous push and pop is legal in any state.
  - With count=DEPTH-2, a push of 2 and a pop of 2 in the same cycle is accepted.
- Full: count=DEPTH-1 or DEPTH gives in_ready=0. No entry is ever overwritten and count never exceeds DEPTH.
- Empty: count=0 gives both out valids=0 and pop_n=0, whatever the stall value.
- flush=1 has priority over push, pop and stall: next cycle head=tail=count=0. A flush together with resetn=0 behaves as reset.
- Wrap-around: a two-entry write or read at index DEPTH-1 uses indices DEPTH-1 and 0.
- Reset or flush mid-stream: no entry from before the event reappears on out_data.
- Single always_ff for state, using nonblocking assignments. All next-state logic is in always_comb.

Decomposition:
- fetch_data_t is reused from the shared common header; no new payload type.
- Add FBUF_DEPTH and fbuf_ptr_t (clog2(FBUF_DEPTH) bits) to the shared package for the core top-level instantiation.
- No sub-module; the queue is a single module.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, then all inputs 0 -> count=0, out valids=0, in_ready=1.
- Steady dual stream: push pairs (pc 0x100/0x104, 0x108/0x10c) with stall=0 -> out_data[1].pc=0x100 and out_data[0].pc=0x104 one cycle after the first push; pop 2 per cycle; count stays at most 2.
- Misalign:
  - Queue holds 0x200(add), 0x204(j); assert branch_misalign -> pop 1.
  - Next cycle out[1].pc=0x204 and out[0].pc=0x208 (delay slot pushed meanwhile).
- Fill and wrap, DEPTH=8:
  - stall=1, push 4 pairs -> count=8, in_ready=0 from count=7 onward; the held push is not lost.
  - Release stall -> entries emerge in order across the index 7->0 boundary.
- Single-slot push: only in_data[0] valid (pc 0x300) -> lands at tail; out[1].pc=0x300, out[0].valid=0.
- Flush with concurrent push/pop: count=5, flush=1 with a push of 2 and stall=0 -> count=0, out valids=0 next cycle, none of the old PCs are observed afterwards.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg
//   Shared types for the F2 -> decode instruction queue.
//   fetch_data_t : one fetched instruction slot (valid, pc, instr).
//   FBUF_DEPTH   : queue depth used by the core top-level instantiation.
//   fbuf_ptr_t   : pointer type sized for FBUF_DEPTH entries.
package fetch_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  localparam int FBUF_DEPTH = 8;

  typedef logic [$clog2(FBUF_DEPTH)-1:0] fbuf_ptr_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if
//   Bundles the fetch-buffer handshake between F2, decode and the queue.
//   in_data[1:0]    : F2 slots, [1] older, [0] younger, per-slot valid
//   in_ready        : queue can take a full two-entry push this cycle
//   out_data[1:0]   : to decode, [1] head (oldest), [0] head+1
//   stall           : decode cannot consume this cycle
//   branch_misalign : out_data[0] is a jump missing its delay slot
//   flush           : redirect, discard everything
//   count           : occupancy (debug/perf)
//   Modport slave is the queue itself; master is the surrounding pipeline.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FBUF_DEPTH
);

  fetch_data_t [1:0]        in_data;
  logic                     in_ready;
  fetch_data_t [1:0]        out_data;
  logic                     stall;
  logic                     branch_misalign;
  logic                     flush;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_data, stall, branch_misalign, flush,
    output in_ready, out_data, count
  );

  modport master (
    output in_data, stall, branch_misalign, flush,
    input  in_ready, out_data, count
  );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   DEPTH-entry circular instruction queue between F2 and decode. Accepts
//   up to two entries per cycle (compacted, age order kept) and presents
//   the two oldest entries. Pops 0/1/2 per cycle; a single pop is used when
//   decode flags branch_misalign so the jump is re-presented as the head.
//   Ports:
//     clk    : clock
//     resetn : synchronous active-low reset
//     bus    : fetch_buffer_if.slave (data in/out, handshake, flush, count)
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FBUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  fetch_buffer_if.slave        bus
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  fetch_data_t mem_r [DEPTH];
  ptr_t        head_r;
  ptr_t        tail_r;
  cnt_t        count_r;

  logic              in_ready_s;
  logic              push_ok_s;
  logic [1:0]        push_n_s;
  logic [1:0]        pop_n_s;
  fetch_data_t       wr0_s;
  fetch_data_t       wr1_s;
  fetch_data_t [1:0] out_s;
  ptr_t              head1_s;
  ptr_t              tail1_s;
  ptr_t              head_nx_s;
  ptr_t              tail_nx_s;
  cnt_t              count_nx_s;

  // Accept/compaction: the oldest valid input always lands at tail.
  always_comb begin
    in_ready_s = ((cnt_t'(DEPTH) - count_r) >= cnt_t'(2));
    push_ok_s  = in_ready_s && !bus.flush;
    tail1_s    = tail_r + ptr_t'(1);
    wr0_s      = bus.in_data[1];
    wr1_s      = bus.in_data[0];
    push_n_s   = 2'd0;
    if (push_ok_s) begin
      case ({bus.in_data[1].valid, bus.in_data[0].valid})
        2'b11:   push_n_s = 2'd2;
        2'b10:   push_n_s = 2'd1;
        2'b01: begin
          push_n_s = 2'd1;
          wr0_s    = bus.in_data[0];
        end
        default: push_n_s = 2'd0;
      endcase
    end else begin
      push_n_s = 2'd0;
    end
  end

  // Read side and pop decision; misalign only matters when slot 0 is valid.
  always_comb begin
    head1_s        = head_r + ptr_t'(1);
    out_s[1]       = mem_r[head_r];
    out_s[1].valid = (count_r >= cnt_t'(1));
    out_s[0]       = mem_r[head1_s];
    out_s[0].valid = (count_r >= cnt_t'(2));
    if (bus.stall) begin
      pop_n_s = 2'd0;
    end else if (out_s[0].valid && !bus.branch_misalign) begin
      pop_n_s = 2'd2;
    end else if (out_s[1].valid) begin
      pop_n_s = 2'd1;
    end else begin
      pop_n_s = 2'd0;
    end
  end

  // Next-state pointers and occupancy; flush clears everything.
  always_comb begin
    if (bus.flush) begin
      head_nx_s  = '0;
      tail_nx_s  = '0;
      count_nx_s = '0;
    end else begin
      head_nx_s  = head_r + ptr_t'(pop_n_s);
      tail_nx_s  = tail_r + ptr_t'(push_n_s);
      count_nx_s = count_r + cnt_t'(push_n_s) - cnt_t'(pop_n_s);
    end
  end

  // Outputs to the interface.
  always_comb begin
    bus.in_ready = in_ready_s;
    bus.out_data = out_s;
    bus.count    = count_r;
  end

  // State update and storage writes (storage itself is not reset).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_nx_s;
      tail_r  <= tail_nx_s;
      count_r <= count_nx_s;
      if (push_n_s != 2'd0) begin
        mem_r[tail_r] <= wr0_s;
      end
      if (push_n_s == 2'd2) begin
        mem_r[tail1_s] <= wr1_s;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
//   Directed bench for fetch_buffer (DEPTH=8). Each scenario task drives
//   inputs just after a rising edge and checks outputs 1 time unit later.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic clk;
  logic resetn;
  int   passed;
  int   total;

  fetch_buffer_if #(.DEPTH(8)) bus ();

  fetch_buffer #(.DEPTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetch_data_t mk(input logic [31:0] pc);
    fetch_data_t d;
    d.valid = 1'b1;
    d.pc    = pc;
    d.instr = pc ^ 32'h5a5a_0000;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_none();
    bus.in_data = '0;
  endtask

  task automatic drive_pair(input logic [31:0] pc_old, input logic [31:0] pc_young);
    bus.in_data[1] = mk(pc_old);
    bus.in_data[0] = mk(pc_young);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.branch_misalign = 1'b0;
    drive_none();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL reset_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.out_data[1].valid !== 1'b0) $display("FAIL reset_v1 got %b want 0", bus.out_data[1].valid); else passed++;
    total++; if (bus.out_data[0].valid !== 1'b0) $display("FAIL reset_v0 got %b want 0", bus.out_data[0].valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_dual_stream();
    drive_pair(32'h100, 32'h104);
    tick();
    total++; if (bus.out_data[1].pc !== 32'h100 || bus.out_data[1].valid !== 1'b1) $display("FAIL stream_h0 got %h want 100", bus.out_data[1].pc); else passed++;
    total++; if (bus.out_data[0].pc !== 32'h104 || bus.out_data[0].valid !== 1'b1) $display("FAIL stream_n0 got %h want 104", bus.out_data[0].pc); else passed++;
    drive_pair(32'h108, 32'h10c);
    tick();
    total++; if (bus.count !== 4'd2) $display("FAIL stream_count got %0d want 2", bus.count); else passed++;
    total++; if (bus.out_data[1].pc !== 32'h108 || bus.out_data[0].pc !== 32'h10c) $display("FAIL stream_pair2 got %h/%h want 108/10c", bus.out_data[1].pc, bus.out_data[0].pc); else passed++;
    drive_none();
    tick();
    total++; if (bus.count !== 4'd0 || bus.out_data[1].valid !== 1'b0) $display("FAIL stream_drain got count %0d v %b want 0/0", bus.count, bus.out_data[1].valid); else passed++;
  endtask

  task automatic test_misalign();
    bus.stall = 1'b1;
    drive_pair(32'h200, 32'h204);
    tick();
    total++; if (bus.count !== 4'd2) $display("FAIL mis_fill got %0d want 2", bus.count); else passed++;
    // Decode holds back the jump; delay slot arrives in the same cycle.
    bus.stall = 1'b0;
    bus.branch_misalign = 1'b1;
    bus.in_data[1] = mk(32'h208);
    bus.in_data[0] = '0;
    tick();
    total++; if (bus.count !== 4'd2) $display("FAIL mis_count got %0d want 2", bus.count); else passed++;
    total++; if (bus.out_data[1].pc !== 32'h204) $display("FAIL mis_head got %h want 204", bus.out_data[1].pc); else passed++;
    total++; if (bus.out_data[0].pc !== 32'h208 || bus.out_data[0].valid !== 1'b1) $display("FAIL mis_slot got %h want 208", bus.out_data[0].pc); else passed++;
    bus.branch_misalign = 1'b0;
    drive_none();
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL mis_drain got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_fill_wrap();
    logic [3:0] exp_cnt;
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_pair(32'h400 + 32'(8 * k), 32'h404 + 32'(8 * k));
      tick();
      exp_cnt = 4'(2 * (k + 1));
      total++; if (bus.count !== exp_cnt) $display("FAIL fill_count%0d got %0d want %0d", k, bus.count, exp_cnt); else passed++;
      total++; if (bus.in_ready !== (k < 3)) $display("FAIL fill_ready%0d got %b want %b", k, bus.in_ready, (k < 3)); else passed++;
    end
    // Held push while full must not be taken.
    drive_pair(32'h420, 32'h424);
    tick();
    total++; if (bus.count !== 4'd8) $display("FAIL full_hold got %0d want 8", bus.count); else passed++;
    total++; if (bus.out_data[1].pc !== 32'h400 || bus.out_data[0].pc !== 32'h404) $display("FAIL full_head got %h/%h want 400/404", bus.out_data[1].pc, bus.out_data[0].pc); else passed++;
    bus.stall = 1'b0;
    tick();
    total++; if (bus.count !== 4'd6 || bus.out_data[1].pc !== 32'h408 || bus.out_data[0].pc !== 32'h40c) $display("FAIL drain1 got %0d %h/%h want 6 408/40c", bus.count, bus.out_data[1].pc, bus.out_data[0].pc); else passed++;
    tick();
    drive_none();
    total++; if (bus.count !== 4'd6 || bus.out_data[1].pc !== 32'h410 || bus.out_data[0].pc !== 32'h414) $display("FAIL drain2 got %0d %h/%h want 6 410/414", bus.count, bus.out_data[1].pc, bus.out_data[0].pc); else passed++;
    tick();
    total++; if (bus.out_data[1].pc !== 32'h418 || bus.out_data[0].pc !== 32'h41c) $display("FAIL drain3 got %h/%h want 418/41c", bus.out_data[1].pc, bus.out_data[0].pc); else passed++;
    tick();
    total++; if (bus.count !== 4'd2 || bus.out_data[1].pc !== 32'h420 || bus.out_data[0].pc !== 32'h424) $display("FAIL drain_wrap got %0d %h/%h want 2 420/424", bus.count, bus.out_data[1].pc, bus.out_data[0].pc); else passed++;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL drain_empty got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_single_slot();
    bus.stall = 1'b1;
    bus.in_data[1] = '0;
    bus.in_data[0] = mk(32'h300);
    tick();
    total++; if (bus.out_data[1].pc !== 32'h300 || bus.out_data[1].valid !== 1'b1) $display("FAIL single_head got %h v %b want 300 v 1", bus.out_data[1].pc, bus.out_data[1].valid); else passed++;
    total++; if (bus.out_data[0].valid !== 1'b0 || bus.count !== 4'd1) $display("FAIL single_slot0 got v %b count %0d want 0/1", bus.out_data[0].valid, bus.count); else passed++;
    // Misalign with slot 0 empty is ignored: a single pop still happens.
    drive_none();
    bus.stall = 1'b0;
    bus.branch_misalign = 1'b1;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL single_pop got %0d want 0", bus.count); else passed++;
    bus.branch_misalign = 1'b0;
    // Empty with stall low pops nothing.
    tick();
    total++; if (bus.count !== 4'd0 || bus.out_data[1].valid !== 1'b0) $display("FAIL empty_idle got %0d v %b want 0/0", bus.count, bus.out_data[1].valid); else passed++;
  endtask

  task automatic test_flush();
    bus.stall = 1'b1;
    drive_pair(32'h500, 32'h504);
    tick();
    drive_pair(32'h508, 32'h50c);
    tick();
    bus.in_data[1] = mk(32'h510);
    bus.in_data[0] = '0;
    tick();
    total++; if (bus.count !== 4'd5) $display("FAIL flush_pre got %0d want 5", bus.count); else passed++;
    bus.flush = 1'b1;
    bus.stall = 1'b0;
    drive_pair(32'h514, 32'h518);
    tick();
    bus.flush = 1'b0;
    drive_none();
    total++; if (bus.count !== 4'd0) $display("FAIL flush_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.out_data[1].valid !== 1'b0 || bus.out_data[0].valid !== 1'b0) $display("FAIL flush_valid got %b%b want 00", bus.out_data[1].valid, bus.out_data[0].valid); else passed++;
    drive_pair(32'h600, 32'h604);
    tick();
    drive_none();
    total++; if (bus.out_data[1].pc !== 32'h600 || bus.out_data[0].pc !== 32'h604 || bus.count !== 4'd2) $display("FAIL flush_after got %h/%h count %0d want 600/604 2", bus.out_data[1].pc, bus.out_data[0].pc, bus.count); else passed++;
    tick();
    total++; if (bus.count !== 4'd0) $display("FAIL flush_drain got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_near_full();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_pair(32'h700 + 32'(8 * k), 32'h704 + 32'(8 * k));
      tick();
    end
    bus.in_data[1] = mk(32'h718);
    bus.in_data[0] = '0;
    tick();
    total++; if (bus.count !== 4'd7 || bus.in_ready !== 1'b0) $display("FAIL seven_ready got count %0d ready %b want 7/0", bus.count, bus.in_ready); else passed++;
    drive_pair(32'h720, 32'h724);
    tick();
    total++; if (bus.count !== 4'd7) $display("FAIL seven_hold got %0d want 7", bus.count); else passed++;
    // Reset and flush together clear the queue.
    resetn = 1'b0;
    bus.flush = 1'b1;
    tick();
    resetn = 1'b1;
    bus.flush = 1'b0;
    drive_none();
    bus.stall = 1'b0;
    total++; if (bus.count !== 4'd0 || bus.out_data[1].valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL rst_mid got count %0d v %b ready %b want 0/0/1", bus.count, bus.out_data[1].valid, bus.in_ready); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_dual_stream();
    test_misalign();
    test_fill_wrap();
    test_single_slot();
    test_flush();
    test_near_full();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
